adder_sched: RTL

Round-robin scheduler that shares one `WIDTH`-bit adder among `N_REQ` requesters, each presenting an operand pair with a valid/ready handshake. It grants one requester per cycle and registers the sum, carry and requester ID into a single-entry result slot with downstream backpressure. It sits between the pin-level operand sources and the adder datapath that drives `uo_out`, and turns a free-running combinational add into a scheduled, shared resource.

---
 rtl/adder_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/adder_sched.sv | 98 +++++++++
 3 files changed

// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared defaults, ID width helper and result record type
// for the round-robin shared-adder scheduler.
package adder_sched_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF = 8;

  // Requester index width; a single requester still needs one ID bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 2) ? unsigned'($clog2(n)) : 1;
  endfunction

  localparam int unsigned ID_W_DEF = id_w(N_REQ_DEF);

  // Result slot contents for the default configuration.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] sum;
    logic                 carry;
    logic [ID_W_DEF-1:0]  id;
  } res_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter. Picks the first asserted
// request at or above ptr, wrapping past N_REQ-1 back to 0.
//   req     in  N_REQ  request vector
//   ptr     in  ID_W   highest-priority index
//   en      in  1      grant enable; low forces no grant
//   gnt     out N_REQ  one-hot grant (or zero)
//   gnt_id  out ID_W   binary index of the grant
//   any_gnt out 1      a grant was issued
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any_gnt
);

  always_comb begin
    logic [ID_W-1:0] idx;
    idx     = '0;
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % N_REQ);
      if (en && !any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_sched.sv
// adder_sched: shares one WIDTH-bit adder among N_REQ valid/ready requesters
// with round-robin grant and a single-entry registered result slot.
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   global enable; low freezes all state
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or 0)
//   op_a, op_b            packed operands, requester i at [i*WIDTH +: WIDTH]
//   res_valid/res_ready   result slot handshake
//   res_sum, res_carry    registered sum and carry out
//   res_id                index of the requester that produced the result
//   busy                  result pending or any request outstanding
// Build option: ADDER_SAT_EN makes the sum saturate to all-ones on carry.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEF,
  parameter  int unsigned WIDTH = WIDTH_DEF,
  localparam int unsigned ID_W  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_sum,
  output logic                   res_carry,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);

  logic [ID_W-1:0]  ptr;
  logic             can_load;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             any_gnt;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_out;

  // rst_n is folded in so no requester sees a ready while reset is held.
  assign can_load = rst_n && ena && (!res_valid || res_ready);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (can_load),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_gnt (any_gnt)
  );

  assign req_ready = gnt;
  assign busy      = res_valid || (|req_valid);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = op_a[i*WIDTH +: WIDTH];
        b_sel = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef ADDER_SAT_EN
  assign sum_out = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];
`else
  assign sum_out = sum_full[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
      ptr       <= '0;
    end else if (ena) begin
      if (any_gnt) begin
        res_valid <= 1'b1;
        res_sum   <= sum_out;
        res_carry <= sum_full[WIDTH];
        res_id    <= gnt_id;
        ptr       <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
